data_sram_responder: RTL and testbench

//  Responder end of the MEM-stage data SRAM port: single-port word RAM with

---
 rtl/data_sram_responder.sv | 121 ++++++++++++
 tb/tb_data_sram_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder end of the MEM-stage data SRAM port. Single-port word RAM with
//   byte-strobe writes and a 1-cycle registered read. Load results are aligned
//   and sign/zero-extended. Misaligned accesses are flagged and suppressed.
//   Committed stores are counted.
// Ports
//   clk       clock
//   reset     synchronous, active-high reset (array contents are kept)
//   en        access valid this cycle
//   we[3:0]   byte write strobes, 0000 = read
//   addr      byte address
//   wdata     store data, already lane-positioned
//   mem_op    0000 ld.b 0001 ld.h 0010 ld.w 1000 ld.bu 1001 ld.hu
//             0100 st.b 0101 st.h 0110 st.w
//   rdata     raw word of the last completed load
//   ld_data   formatted result of the last completed load
//   rvalid    one-cycle pulse: load completed
//   ale       one-cycle pulse: misaligned access dropped
//   wr_count  committed store count, wraps at 16 bits
module data_sram_responder #(
  parameter int          ADDR_W = 14,
  parameter logic [31:0] BASE   = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  mem_op,
  output logic [31:0] rdata,
  output logic [31:0] ld_data,
  output logic        rvalid,
  output logic        ale,
  output logic [15:0] wr_count
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]       off_addr;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  // Out-of-range addresses wrap: only the low ADDR_W word-index bits are kept.
  assign off_addr    = addr - BASE;
  assign idx         = off_addr[ADDR_W+1:2];
  assign unused_bits = ^{off_addr[31:ADDR_W+2], off_addr[1:0]};

  logic is_ld_op, h_op, w_op, bad_align;
  logic mis, wr_ok, rd_ok;

  always_comb begin
    is_ld_op = 1'b0;
    h_op     = 1'b0;
    w_op     = 1'b0;
    case (mem_op)
      4'b0000, 4'b1000: is_ld_op = 1'b1;
      4'b0001, 4'b1001: begin is_ld_op = 1'b1; h_op = 1'b1; end
      4'b0010:          begin is_ld_op = 1'b1; w_op = 1'b1; end
      4'b0101:          h_op = 1'b1;
      4'b0110:          w_op = 1'b1;
      default: ;
    endcase
    // Strobes with a load op code: the strobes win and no alignment check applies.
    bad_align = ~((|we) & is_ld_op) &
                ((h_op & addr[0]) | (w_op & (|addr[1:0])));
    mis   = en & bad_align;
    wr_ok = en & (|we) & ~bad_align & ~reset;
    rd_ok = en & ~(|we) & ~bad_align;
  end

  // Array: no reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic [1:0] off_q;
  logic [3:0] op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      ale      <= 1'b0;
      wr_count <= '0;
      off_q    <= '0;
      op_q     <= '0;
    end else begin
      rvalid <= rd_ok;
      ale    <= mis;
      if (rd_ok) begin
        rdata <= mem[idx];
        off_q <= addr[1:0];
        op_q  <= mem_op;
      end
      if (wr_ok) wr_count <= wr_count + 16'd1;
    end
  end

  // Formatting works only from registered state, so ld_data holds along with
  // rdata whenever no load completes.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*off_q +: 8];
    half_sel = off_q[1] ? rdata[31:16] : rdata[15:0];
    case (op_q)
      4'b0000: ld_data = {{24{byte_sel[7]}}, byte_sel};
      4'b1000: ld_data = {24'h0, byte_sel};
      4'b0001: ld_data = {{16{half_sel[15]}}, half_sel};
      4'b1001: ld_data = {16'h0, half_sel};
      default: ld_data = rdata;
    endcase
  end
endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr, wdata;
  logic [3:0]  mem_op;
  logic [31:0] rdata, ld_data;
  logic        rvalid, ale;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .mem_op(mem_op), .rdata(rdata), .ld_data(ld_data), .rvalid(rvalid),
    .ale(ale), .wr_count(wr_count)
  );

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  op;
    logic        rv;
    logic        ale;
    logic [31:0] rd;
    logic [31:0] ld;
    logic [15:0] wc;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(logic e, logic [3:0] w, logic [31:0] a,
                              logic [31:0] d, logic [3:0] o, logic rv,
                              logic al, logic [31:0] rd, logic [31:0] ld,
                              logic [15:0] wc);
    vec_t v;
    v.en = e; v.we = w; v.addr = a; v.wdata = d; v.op = o;
    v.rv = rv; v.ale = al; v.rd = rd; v.ld = ld; v.wc = wc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] o);
    en = e; we = w; addr = a; wdata = d; mem_op = o;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " rvalid"},   {31'h0, rvalid}, {31'h0, v.rv});
    chk({tag, " ale"},      {31'h0, ale},    {31'h0, v.ale});
    chk({tag, " rdata"},    rdata,           v.rd);
    chk({tag, " ld_data"},  ld_data,         v.ld);
    chk({tag, " wr_count"}, {16'h0, wr_count}, {16'h0, v.wc});
  endtask

  initial begin
    // Store, load, byte/half formatting, misalignment, inconsistent inputs, wrap.
    vecs.push_back(mk(1, 4'hF, 32'h1c000010, 32'h11223344, 4'b0110, 0, 0, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, 4'h0, 32'h1c000010, 32'h0,        4'b0010, 1, 0, 32'h11223344, 32'h11223344, 1));
    vecs.push_back(mk(1, 4'h4, 32'h1c000012, 32'h00AA0000, 4'b0100, 0, 0, 32'h11223344, 32'h11223344, 2));
    vecs.push_back(mk(1, 4'h0, 32'h1c000012, 32'h0,        4'b0000, 1, 0, 32'h11AA3344, 32'hFFFFFFAA, 2));
    vecs.push_back(mk(1, 4'h0, 32'h1c000012, 32'h0,        4'b1000, 1, 0, 32'h11AA3344, 32'h000000AA, 2));
    vecs.push_back(mk(1, 4'hF, 32'h1c000010, 32'h80010000, 4'b0110, 0, 0, 32'h11AA3344, 32'h000000AA, 3));
    vecs.push_back(mk(1, 4'h0, 32'h1c000012, 32'h0,        4'b0001, 1, 0, 32'h80010000, 32'hFFFF8001, 3));
    vecs.push_back(mk(1, 4'h0, 32'h1c000012, 32'h0,        4'b1001, 1, 0, 32'h80010000, 32'h00008001, 3));
    vecs.push_back(mk(1, 4'h0, 32'h1c000010, 32'h0,        4'b0001, 1, 0, 32'h80010000, 32'h00000000, 3));
    vecs.push_back(mk(0, 4'h0, 32'h1c000010, 32'h0,        4'b0010, 0, 0, 32'h80010000, 32'h00000000, 3));
    vecs.push_back(mk(1, 4'hF, 32'h1c000020, 32'hCAFEBABE, 4'b0110, 0, 0, 32'h80010000, 32'h00000000, 4));
    vecs.push_back(mk(1, 4'hF, 32'h1c000022, 32'hDEADBEEF, 4'b0110, 0, 1, 32'h80010000, 32'h00000000, 4));
    vecs.push_back(mk(1, 4'h0, 32'h1c000020, 32'h0,        4'b0010, 1, 0, 32'hCAFEBABE, 32'hCAFEBABE, 4));
    vecs.push_back(mk(1, 4'h0, 32'h1c000021, 32'h0,        4'b0001, 0, 1, 32'hCAFEBABE, 32'hCAFEBABE, 4));
    vecs.push_back(mk(1, 4'h0, 32'h1c000023, 32'h0,        4'b0000, 1, 0, 32'hCAFEBABE, 32'hFFFFFFCA, 4));
    vecs.push_back(mk(1, 4'h1, 32'h1c000021, 32'h00000055, 4'b0010, 0, 0, 32'hCAFEBABE, 32'hFFFFFFCA, 5));
    vecs.push_back(mk(1, 4'h0, 32'h1c000020, 32'h0,        4'b0010, 1, 0, 32'hCAFEBA55, 32'hCAFEBA55, 5));
    vecs.push_back(mk(1, 4'h3, 32'h1c000031, 32'h0000BEEF, 4'b0101, 0, 1, 32'hCAFEBA55, 32'hCAFEBA55, 5));
    vecs.push_back(mk(1, 4'hF, 32'h1c010000, 32'h12345678, 4'b0110, 0, 0, 32'hCAFEBA55, 32'hCAFEBA55, 6));
    vecs.push_back(mk(1, 4'h0, 32'h1c000000, 32'h0,        4'b0010, 1, 0, 32'h12345678, 32'h12345678, 6));
    vecs.push_back(mk(1, 4'h0, 32'h1c000000, 32'h0,        4'b0111, 1, 0, 32'h12345678, 32'h12345678, 6));
    vecs.push_back(mk(1, 4'h0, 32'h1c000000, 32'h0,        4'b1001, 1, 0, 32'h12345678, 32'h00005678, 6));
    vecs.push_back(mk(1, 4'h0, 32'h1c000001, 32'h0,        4'b0000, 1, 0, 32'h12345678, 32'h00000056, 6));
    vecs.push_back(mk(1, 4'hF, 32'h1c000030, 32'h00000000, 4'b0110, 0, 0, 32'h12345678, 32'h00000056, 7));

    reset = 1'b1;
    drive(0, 4'h0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].op);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset together with a store: store dropped, outputs cleared.
    reset = 1'b1;
    drive(1, 4'hF, 32'h1c000030, 32'h00000099, 4'b0110);
    @(negedge clk);
    reset = 1'b0;
    check_all("rst_mid", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));

    // Array contents survive reset; the dropped store left word 0x30 at 0.
    drive(1, 4'h0, 32'h1c000020, 32'h0, 4'b0010);
    @(negedge clk);
    chk("retain rdata", rdata, 32'hCAFEBA55);
    chk("retain rvalid", {31'h0, rvalid}, 32'h1);
    drive(1, 4'h0, 32'h1c000030, 32'h0, 4'b0010);
    @(negedge clk);
    chk("dropped store", rdata, 32'h00000000);
    chk("dropped count", {16'h0, wr_count}, 32'h0);

    // Counter wrap: 65535 stores reach 0xFFFF, one more wraps to 0.
    drive(1, 4'hF, 32'h1c000040, 32'h0, 4'b0110);
    for (int i = 0; i < 65535; i++) begin
      wdata = i;
      @(negedge clk);
    end
    chk("wc ffff", {16'h0, wr_count}, 32'h0000FFFF);
    @(negedge clk);
    chk("wc wrap", {16'h0, wr_count}, 32'h0);
    chk("store rvalid", {31'h0, rvalid}, 32'h0);
    drive(0, 4'h0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    drive(1, 4'h0, 32'h1c000040, 32'h0, 4'b0010);
    @(negedge clk);
    chk("last store data", rdata, 32'h00000000 + 32'd65535 - 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
